// File: rtl/dct_pkg.sv
// Shared types and helpers for the DCT transpose buffer.
// Holds bank/read states and the transpose address mapping.
package dct_pkg;

  localparam int N_DEF     = 8;
  localparam int WIDTH_DEF = 10;
  localparam int ADDR_W    = $clog2(N_DEF * N_DEF);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_state_t;

  typedef enum logic {
    IDLE,
    READ
  } rd_state_t;

  // Column-major walk over a row-major N x N block.
  function automatic logic [31:0] tr_addr(
    input logic [31:0] k,
    input logic [31:0] n
  );
    return (k % n) * n + (k / n);
  endfunction

endpackage

// File: rtl/dct_transpose_buffer_ram.sv
// Simple dual-port RAM: synchronous write, registered read.
// Both ping-pong banks share it; the bank select is the address MSB.
module transpose_bank_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 10,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array and read-data register.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong transpose buffer between the row and column DCT passes.
// Optional Out_Sof start-of-block flag: define DCT_TRANSPOSE_SOF_EN.
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    En_In,
  input  logic signed [WIDTH-1:0] In_Data,
  input  logic                    Mode,
  input  logic                    Out_Ready,
  output logic                    En_Out,
  output logic signed [WIDTH-1:0] Out_Data,
  output logic                    Overflow
`ifdef DCT_TRANSPOSE_SOF_EN
  ,
  output logic                    Out_Sof
`endif
);

  localparam int NN = N * N;
  localparam int AW = $clog2(NN);
  localparam logic [AW-1:0] LAST = AW'(NN - 1);

  bank_state_t bst_q [2];
  bank_state_t bst_d [2];
  logic [1:0]  bmode_q, bmode_d;
  logic        wbank_q, wbank_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic        ovf_q, ovf_d;

  rd_state_t   rstate_q, rstate_d;
  logic        rbank_q, rbank_d;
  logic [AW-1:0] rcnt_q, rcnt_d;
  logic        v1_q, v1_d;

  logic        ov_q, ov_d;
  logic [WIDTH-1:0] od_q, od_d;
  logic        sv_q, sv_d;
  logic [WIDTH-1:0] sd_q, sd_d;

`ifdef DCT_TRANSPOSE_SOF_EN
  logic        sof1_q, sof1_d;
  logic        osof_q, osof_d;
  logic        ssof_q, ssof_d;
`endif

  logic          wr_ok;
  logic          issue;
  logic          rd_done;
  logic          pop;
  logic          can_issue;
  logic [1:0]    occ;
  logic [AW-1:0] tr_a;
  logic [AW-1:0] rd_a;
  logic [WIDTH-1:0] ram_q;

  assign wr_ok = En_In && (bst_q[wbank_q] != FULL);
  assign pop   = ov_q && Out_Ready;
  assign occ   = {1'b0, ov_q} + {1'b0, sv_q} + {1'b0, v1_q};
  assign can_issue = (occ - {1'b0, pop}) <= 2'd1;
  assign tr_a  = AW'(tr_addr(32'(rcnt_q), 32'(N)));
  assign rd_a  = bmode_q[rbank_q] ? tr_a : rcnt_q;

  transpose_bank_ram #(
    .DEPTH(2 * NN),
    .WIDTH(WIDTH),
    .AW   (AW + 1)
  ) u_ram (
    .clk  (Clock),
    .we   (wr_ok),
    .waddr({wbank_q, wcnt_q}),
    .wdata(In_Data),
    .re   (issue),
    .raddr({rbank_q, rd_a}),
    .rdata(ram_q)
  );

  // Write side and bank bookkeeping; reader frees, writer fills.
  always_comb begin
    bst_d   = bst_q;
    bmode_d = bmode_q;
    wbank_d = wbank_q;
    wcnt_d  = wcnt_q;
    ovf_d   = ovf_q | (En_In & ~wr_ok);
    if (wr_ok) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == '0) begin
        bmode_d[wbank_q] = Mode;
        bst_d[wbank_q]   = FILLING;
      end
      if (wcnt_q == LAST) begin
        bst_d[wbank_q] = FULL;
        wcnt_d         = '0;
        wbank_d        = ~wbank_q;
      end
    end
    if (rd_done) bst_d[rbank_q] = EMPTY;
  end

  // Read FSM: issues one address per cycle while there is room.
  always_comb begin
    rstate_d = rstate_q;
    rbank_d  = rbank_q;
    rcnt_d   = rcnt_q;
    issue    = 1'b0;
    rd_done  = 1'b0;
    unique case (rstate_q)
      IDLE: begin
        if (bst_q[rbank_q] == FULL) begin
          rstate_d = READ;
          issue    = can_issue;
        end
      end
      READ: issue = can_issue;
      default: rstate_d = IDLE;
    endcase
    if (issue) begin
      rcnt_d = rcnt_q + 1'b1;
      if (rcnt_q == LAST) begin
        rcnt_d   = '0;
        rd_done  = 1'b1;
        rbank_d  = ~rbank_q;
        rstate_d = (bst_q[~rbank_q] == FULL) ? READ : IDLE;
      end
    end
    v1_d = issue;
  end

  // Output register plus one-entry skid, fed by the RAM read.
  always_comb begin
    ov_d = ov_q;
    od_d = od_q;
    sv_d = sv_q;
    sd_d = sd_q;
`ifdef DCT_TRANSPOSE_SOF_EN
    sof1_d = issue && (rcnt_q == '0);
    osof_d = osof_q;
    ssof_d = ssof_q;
`endif
    if (pop) begin
      ov_d = sv_q;
      sv_d = 1'b0;
      if (sv_q) od_d = sd_q;
`ifdef DCT_TRANSPOSE_SOF_EN
      if (sv_q) osof_d = ssof_q;
`endif
    end
    if (v1_q) begin
      if (!ov_d) begin
        ov_d = 1'b1;
        od_d = ram_q;
`ifdef DCT_TRANSPOSE_SOF_EN
        osof_d = sof1_q;
`endif
      end else begin
        sv_d = 1'b1;
        sd_d = ram_q;
`ifdef DCT_TRANSPOSE_SOF_EN
        ssof_d = sof1_q;
`endif
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      bst_q[0] <= EMPTY;
      bst_q[1] <= EMPTY;
      bmode_q  <= '0;
      wbank_q  <= 1'b0;
      wcnt_q   <= '0;
      ovf_q    <= 1'b0;
      rstate_q <= IDLE;
      rbank_q  <= 1'b0;
      rcnt_q   <= '0;
      v1_q     <= 1'b0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      sv_q     <= 1'b0;
      sd_q     <= '0;
`ifdef DCT_TRANSPOSE_SOF_EN
      sof1_q   <= 1'b0;
      osof_q   <= 1'b0;
      ssof_q   <= 1'b0;
`endif
    end else begin
      bst_q    <= bst_d;
      bmode_q  <= bmode_d;
      wbank_q  <= wbank_d;
      wcnt_q   <= wcnt_d;
      ovf_q    <= ovf_d;
      rstate_q <= rstate_d;
      rbank_q  <= rbank_d;
      rcnt_q   <= rcnt_d;
      v1_q     <= v1_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      sv_q     <= sv_d;
      sd_q     <= sd_d;
`ifdef DCT_TRANSPOSE_SOF_EN
      sof1_q   <= sof1_d;
      osof_q   <= osof_d;
      ssof_q   <= ssof_d;
`endif
    end
  end

  assign En_Out   = ov_q;
  assign Out_Data = od_q;
  assign Overflow = ovf_q;
`ifdef DCT_TRANSPOSE_SOF_EN
  assign Out_Sof  = ov_q & osof_q;
`endif

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed bench for dct_transpose_buffer (N=8, WIDTH=10).
// Covers latency, modes, back-to-back, stall, overflow, reset.
module tb_dct_transpose_buffer;

  localparam int N  = 8;
  localparam int W  = 10;
  localparam int NN = N * N;

  logic                clk = 1'b0;
  logic                Reset = 1'b1;
  logic                En_In = 1'b0;
  logic signed [W-1:0] In_Data = '0;
  logic                Mode = 1'b0;
  logic                Out_Ready = 1'b1;
  logic                En_Out;
  logic signed [W-1:0] Out_Data;
  logic                Overflow;
`ifdef DCT_TRANSPOSE_SOF_EN
  logic                Out_Sof;
`endif

  dct_transpose_buffer #(
    .N    (N),
    .WIDTH(W)
  ) dut (
    .Clock    (clk),
    .Reset    (Reset),
    .En_In    (En_In),
    .In_Data  (In_Data),
    .Mode     (Mode),
    .Out_Ready(Out_Ready),
    .En_Out   (En_Out),
    .Out_Data (Out_Data),
    .Overflow (Overflow)
`ifdef DCT_TRANSPOSE_SOF_EN
    ,
    .Out_Sof  (Out_Sof)
`endif
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  int checks = 0;
  int errors = 0;
  int last_wr = 0;
  int got[$];
  int gotc[$];

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(string tag, int obs, int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Record every accepted output and the edge it appeared after.
  always @(negedge clk) begin
    if (En_Out && Out_Ready) begin
`ifdef DCT_TRANSPOSE_SOF_EN
      check("sof", int'(Out_Sof), int'(got.size() % NN == 0));
`endif
      got.push_back(int'(Out_Data));
      gotc.push_back(ecnt);
    end
  end

  function automatic int tr_val(int base, int k);
    return base + (k % N) * N + k / N;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    got.delete();
    gotc.delete();
  endtask

  task automatic feed(int base, bit md, int n);
    for (int i = 0; i < n; i++) begin
      En_In   = 1'b1;
      In_Data = W'(base + i);
      Mode    = md;
      tick();
    end
    last_wr = ecnt;
    En_In   = 1'b0;
  endtask

  task automatic wait_out(int n, int budget, string tag);
    int b;
    b = 0;
    while (got.size() < n && b < budget) begin
      tick();
      b++;
    end
    if (got.size() < n) check(tag, got.size(), n);
  endtask

  task automatic check_blk(string tag, int off, int base, bit tr);
    int v;
    int e;
    for (int k = 0; k < NN; k++) begin
      v = (off + k < got.size()) ? got[off + k] : -99999;
      e = tr ? tr_val(base, k) : base + k;
      check(tag, v, e);
    end
  endtask

  task automatic check_gaps(string tag);
    int bad;
    bad = 0;
    for (int i = 1; i < gotc.size(); i++)
      if (gotc[i] != gotc[0] + i) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b;
    int wr;
    #1;
    repeat (2) tick();
    Reset = 1'b0;
    check("rst en_out", int'(En_Out), 0);
    check("rst out_data", int'(Out_Data), 0);
    check("rst overflow", int'(Overflow), 0);
    repeat (3) tick();
    check("idle en_out", int'(En_Out), 0);

    // Transposed block, latency and contiguity.
    clear();
    feed(0, 1'b1, NN);
    wr = last_wr;
    wait_out(NN, 300, "t1 timeout");
    repeat (5) tick();
    check("t1 count", got.size(), NN);
    check("t1 latency", (gotc.size() > 0) ? gotc[0] : -1, wr + 2);
    check_blk("t1 data", 0, 0, 1'b1);
    check_gaps("t1 gaps");
    check("t1 overflow", int'(Overflow), 0);

    // Pass-through then negative transposed block.
    clear();
    feed(0, 1'b0, NN);
    feed(-200, 1'b1, NN);
    wait_out(2 * NN, 400, "t2 timeout");
    repeat (5) tick();
    check("t2 count", got.size(), 2 * NN);
    check_blk("t2 pass", 0, 0, 1'b0);
    check_blk("t2 trans", NN, -200, 1'b1);

    // Three blocks back-to-back.
    clear();
    feed(0, 1'b1, NN);
    feed(64, 1'b1, NN);
    feed(128, 1'b1, NN);
    wait_out(3 * NN, 500, "t3 timeout");
    repeat (5) tick();
    check("t3 count", got.size(), 3 * NN);
    check_blk("t3 blk0", 0, 0, 1'b1);
    check_blk("t3 blk1", NN, 64, 1'b1);
    check_blk("t3 blk2", 2 * NN, 128, 1'b1);
    check_gaps("t3 gaps");
    check("t3 overflow", int'(Overflow), 0);

    // Backpressure at output index 20.
    clear();
    feed(0, 1'b1, NN);
    b = 0;
    while (got.size() < 20 && b < 300) begin
      tick();
      b++;
    end
    Out_Ready = 1'b0;
    check("t4 at20", int'(Out_Data), tr_val(0, 20));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4 hold en", int'(En_Out), 1);
      check("t4 hold data", int'(Out_Data), tr_val(0, 20));
    end
    Out_Ready = 1'b1;
    wait_out(NN, 300, "t4 timeout");
    repeat (5) tick();
    check("t4 count", got.size(), NN);
    check_blk("t4 data", 0, 0, 1'b1);

    // Overflow with output blocked.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    clear();
    Out_Ready = 1'b0;
    feed(0, 1'b1, NN);
    feed(64, 1'b1, NN);
    check("t5 ovf before", int'(Overflow), 0);
    feed(128, 1'b1, 1);
    check("t5 ovf at blk3", int'(Overflow), 1);
    feed(129, 1'b1, NN - 1);
    repeat (5) tick();
    check("t5 blocked count", got.size(), 0);
    Out_Ready = 1'b1;
    wait_out(2 * NN, 500, "t5 timeout");
    repeat (80) tick();
    check("t5 count", got.size(), 2 * NN);
    check_blk("t5 blk1", 0, 0, 1'b1);
    check_blk("t5 blk2", NN, 64, 1'b1);

    // Reset mid-output while the next block fills.
    check("t6 ovf sticky", int'(Overflow), 1);
    clear();
    feed(0, 1'b1, NN);
    feed(64, 1'b1, 30);
    check("t6 midout", int'(En_Out), 1);
    Reset = 1'b1;
    tick();
    check("t6 rst en_out", int'(En_Out), 0);
    check("t6 rst ovf", int'(Overflow), 0);
    check("t6 rst data", int'(Out_Data), 0);
    Reset = 1'b0;
    repeat (3) tick();
    check("t6 quiet", int'(En_Out), 0);
    clear();
    feed(300, 1'b0, NN);
    wr = last_wr;
    wait_out(NN, 300, "t6 timeout");
    repeat (10) tick();
    check("t6 count", got.size(), NN);
    check("t6 latency", (gotc.size() > 0) ? gotc[0] : -1, wr + 2);
    check_blk("t6 data", 0, 300, 1'b0);
    check_gaps("t6 gaps");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
